// File: rtl/is_array_feeder_pkg.sv
// rtl/is_array_feeder_pkg.sv - shared state encoding and load timing for the array feeder
//
// Purpose: FSM state type and activation-load timing constants shared by the
// feeder top and its helpers.
// Contents:
//   state_t      - feeder FSM states
//   LOAD_FACTOR  - cycles per PE for the activation-load enable to ripple down a row
//   load_cycles  - total LOAD duration for a given column count

package is_array_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Each PE registers the load enable twice before handing it on.
  localparam int LOAD_FACTOR = 2;

  function automatic int load_cycles(input int cols);
    return LOAD_FACTOR * cols;
  endfunction

endpackage

// File: rtl/is_array_feeder_skew.sv
// rtl/is_array_feeder_skew.sv - fixed-depth delay line carrying one weight lane plus its valid bit
//
// Purpose: delays one weight lane by DEPTH cycles so lane r reaches its array
// row r+1 cycles after acceptance. Shifts every cycle (no backpressure).
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset, empties the line
//   clear     in   synchronous clear, empties the line
//   in_data   in   lane data entering the line
//   in_valid  in   lane valid entering the line
//   out_data  out  lane data after DEPTH registers (zero when invalid)
//   out_valid out  lane valid after DEPTH registers

module is_skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  // Bit WIDTH is the valid flag, bits WIDTH-1:0 the lane data.
  logic [WIDTH:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      // Data is masked on entry so a bubble always travels as all-zero.
      stage[0] <= {in_valid, (in_valid ? in_data : {WIDTH{1'b0}})};
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign out_valid = stage[DEPTH-1][WIDTH];
  assign out_data  = stage[DEPTH-1][WIDTH-1:0];

endmodule

// File: rtl/is_array_feeder.sv
// rtl/is_array_feeder.sv - sequences activation load and streams skewed weights into a systolic array
//
// Purpose: on start, pulses the activation-load enable for the whole column
// chain, then accepts weight beats and skews lane r by r+1 cycles toward the
// array, drains the skew lines after the last beat and pulses done.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          begin a tile (honoured in IDLE only)
//   reg_clear      synchronous clear of all state
//   s_valid/s_ready/s_data/s_last  weight beat stream in
//   cell_sc_en_o   activation-load enable to column 0
//   cell_en_o      per-row lane valid
//   pipeline_en_o  array pipeline enable (STREAM and DRAIN)
//   wei_o          skewed weight lanes
//   busy           FSM not in IDLE
//   done           one-cycle completion pulse
//   k_count        beats accepted this tile (saturating)

module is_array_feeder
  import is_array_feeder_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int WIDTH_B = 16,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    reg_clear,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [ROWS*WIDTH_B-1:0] s_data,
  input  logic                    s_last,
  output logic                    cell_sc_en_o,
  output logic [ROWS-1:0]         cell_en_o,
  output logic                    pipeline_en_o,
  output logic [ROWS*WIDTH_B-1:0] wei_o,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        k_count
);

  localparam int LOAD_CYCLES = load_cycles(COLS);
  localparam int LCW         = $clog2(LOAD_CYCLES + 1);
  localparam int DCW         = $clog2(ROWS + 1);

  state_t           state;
  logic [LCW-1:0]   load_cnt;
  logic [DCW-1:0]   drain_cnt;
  logic             accept;

  assign accept = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      load_cnt      <= '0;
      drain_cnt     <= '0;
      s_ready       <= 1'b0;
      cell_sc_en_o  <= 1'b0;
      pipeline_en_o <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      k_count       <= '0;
    end else if (reg_clear) begin
      state         <= ST_IDLE;
      load_cnt      <= '0;
      drain_cnt     <= '0;
      s_ready       <= 1'b0;
      cell_sc_en_o  <= 1'b0;
      pipeline_en_o <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      k_count       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_LOAD;
            k_count      <= '0;
            load_cnt     <= '0;
            cell_sc_en_o <= 1'b1;
            busy         <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_cnt == LCW'(LOAD_CYCLES - 1)) begin
            state         <= ST_STREAM;
            cell_sc_en_o  <= 1'b0;
            s_ready       <= 1'b1;
            pipeline_en_o <= 1'b1;
          end else begin
            load_cnt <= load_cnt + LCW'(1);
          end
        end
        ST_STREAM: begin
          if (accept) begin
            if (k_count != {CNT_W{1'b1}}) k_count <= k_count + CNT_W'(1);
            if (s_last) begin
              state     <= ST_DRAIN;
              s_ready   <= 1'b0;
              drain_cnt <= '0;
            end
          end
        end
        ST_DRAIN: begin
          // ROWS bubble cycles push the deepest lane's last beat out.
          if (drain_cnt == DCW'(ROWS - 1)) begin
            state         <= ST_DONE;
            pipeline_en_o <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        ST_DONE: begin
          // done is registered off the DONE state, so it coincides with the
          // first IDLE cycle.
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Lane r passes through r+1 registers; non-accept cycles enter as bubbles.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    is_skew_line #(
      .DEPTH(r + 1),
      .WIDTH(WIDTH_B)
    ) u_skew (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (reg_clear),
      .in_data  (s_data[r*WIDTH_B +: WIDTH_B]),
      .in_valid (accept),
      .out_data (wei_o[r*WIDTH_B +: WIDTH_B]),
      .out_valid(cell_en_o[r])
    );
  end

endmodule

// File: tb/tb_is_array_feeder.sv
// tb/tb_is_array_feeder.sv - scoreboard bench for the skewed weight feeder

module tb_is_array_feeder;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0, reg_clear = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [ROWS*W-1:0] s_data = '0;
  logic              s_ready, cell_sc_en, pipeline_en, busy, done;
  logic [ROWS-1:0]   cell_en;
  logic [ROWS*W-1:0] wei;
  logic [7:0]        k_count;

  logic              start2 = 1'b0, s_valid2 = 1'b0, s_last2 = 1'b0;
  logic [ROWS*W-1:0] s_data2 = '0;
  logic              s_ready2, cell_sc_en2, pipeline_en2, busy2, done2;
  logic [ROWS-1:0]   cell_en2;
  logic [ROWS*W-1:0] wei2;
  logic [1:0]        k_count2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         exp_cyc_q [ROWS][$];
  logic [W-1:0] exp_dat_q [ROWS][$];
  int         done_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  is_array_feeder #(.ROWS(ROWS), .COLS(COLS), .WIDTH_B(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reg_clear(reg_clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .cell_sc_en_o(cell_sc_en), .cell_en_o(cell_en), .pipeline_en_o(pipeline_en),
    .wei_o(wei), .busy(busy), .done(done), .k_count(k_count)
  );

  is_array_feeder #(.ROWS(ROWS), .COLS(COLS), .WIDTH_B(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .reg_clear(1'b0),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2), .s_last(s_last2),
    .cell_sc_en_o(cell_sc_en2), .cell_en_o(cell_en2), .pipeline_en_o(pipeline_en2),
    .wei_o(wei2), .busy(busy2), .done(done2), .k_count(k_count2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every lane and the done pulse are matched against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        if (cell_en[r]) begin
          if (exp_cyc_q[r].size() == 0) begin
            chk($sformatf("lane%0d_unexpected_valid", r), 64'(cell_en[r]), 64'(0));
          end else begin
            int ec;
            logic [W-1:0] ed;
            ec = exp_cyc_q[r].pop_front();
            ed = exp_dat_q[r].pop_front();
            chk($sformatf("lane%0d_cycle", r), 64'(cyc), 64'(ec));
            chk($sformatf("lane%0d_data", r), 64'(wei[r*W +: W]), 64'(ed));
          end
        end else begin
          chk($sformatf("lane%0d_bubble_zero", r), 64'(wei[r*W +: W]), 64'(0));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 64'(done), 64'(0));
        end else begin
          int dc;
          dc = done_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(dc));
        end
      end
    end
  end

  // Called at a negedge while IDLE; start is high during cycle 0.
  task automatic load_phase();
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      chk($sformatf("sc_en_k%0d", k), 64'(cell_sc_en), 64'(k <= 2*COLS));
      chk($sformatf("s_ready_k%0d", k), 64'(s_ready), 64'(k == 2*COLS + 1));
    end
  endtask

  task automatic send_beat(input logic [ROWS*W-1:0] d, input logic last);
    int n;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_wait", 64'(s_ready), 64'(1));
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int r = 0; r < ROWS; r++) begin
      exp_cyc_q[r].push_back(cyc + r + 1);
      exp_dat_q[r].push_back(d[r*W +: W]);
    end
    if (last) done_q.push_back(cyc + ROWS + 2);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_pending", 64'(done_q.size()), 64'(0));
    done_q.delete();
    @(negedge clk);
  endtask

  task automatic flush_queues();
    for (int r = 0; r < ROWS; r++) begin
      exp_cyc_q[r].delete();
      exp_dat_q[r].delete();
    end
    done_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_sc_en", 64'(cell_sc_en), 64'(0));
    chk("rst_cell_en", 64'(cell_en), 64'(0));
    chk("rst_pipeline_en", 64'(pipeline_en), 64'(0));
    chk("rst_wei", 64'(wei), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_k_count", 64'(k_count), 64'(0));
    chk("rst_sat_outs", 64'({s_ready2, cell_sc_en2, cell_en2, pipeline_en2, busy2, done2, k_count2}), 64'(0));
    chk("rst_sat_wei", 64'(wei2), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Tile 1: single beat, lane r carries r+1.
    load_phase();
    send_beat(64'h0004_0003_0002_0001, 1'b1);
    chk("t1_drain_pipeline_en", 64'(pipeline_en), 64'(1));
    chk("t1_drain_s_ready", 64'(s_ready), 64'(0));
    wait_done();
    chk("t1_idle_busy", 64'(busy), 64'(0));
    chk("t1_k_count", 64'(k_count), 64'(1));
    chk("t1_idle_pipeline_en", 64'(pipeline_en), 64'(0));

    // Tile 2: beat, bubble (with ignored start and lone s_last), two beats.
    load_phase();
    send_beat(64'hA004_A003_A002_A001, 1'b0);
    start  = 1'b1;
    s_last = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    s_last = 1'b0;
    chk("t2_still_stream_ready", 64'(s_ready), 64'(1));
    chk("t2_no_reload_sc_en", 64'(cell_sc_en), 64'(0));
    chk("t2_busy", 64'(busy), 64'(1));
    chk("t2_pipeline_en", 64'(pipeline_en), 64'(1));
    send_beat(64'hB004_B003_B002_B001, 1'b0);
    send_beat(64'hC004_C003_C002_C001, 1'b1);
    wait_done();
    chk("t2_k_count", 64'(k_count), 64'(3));
    chk("t2_idle_cell_en", 64'(cell_en), 64'(0));

    // Tile 3: reg_clear during DRAIN aborts without done.
    load_phase();
    send_beat(64'hD004_D003_D002_D001, 1'b1);
    reg_clear = 1'b1;
    @(negedge clk);
    reg_clear = 1'b0;
    flush_queues();
    chk("clr_busy", 64'(busy), 64'(0));
    chk("clr_s_ready", 64'(s_ready), 64'(0));
    chk("clr_pipeline_en", 64'(pipeline_en), 64'(0));
    chk("clr_cell_en", 64'(cell_en), 64'(0));
    chk("clr_wei", 64'(wei), 64'(0));
    chk("clr_done", 64'(done), 64'(0));
    chk("clr_k_count", 64'(k_count), 64'(0));
    repeat (10) @(negedge clk);
    chk("clr_stays_idle", 64'(busy), 64'(0));

    // Saturating counter on the CNT_W=2 instance.
    start2 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) start2 = 1'b0;
    end
    chk("sat_s_ready", 64'(s_ready2), 64'(1));
    for (int i = 0; i < 6; i++) begin
      s_valid2 = 1'b1;
      s_last2  = (i == 5);
      s_data2  = 64'(i);
      @(negedge clk);
      chk($sformatf("sat_k_count_b%0d", i + 1), 64'(k_count2), 64'((i + 1 > 3) ? 3 : i + 1));
    end
    s_valid2 = 1'b0;
    s_last2  = 1'b0;
    repeat (8) @(negedge clk);
    chk("sat_final_k_count", 64'(k_count2), 64'(3));
    chk("sat_idle", 64'({busy2, cell_en2, pipeline_en2, cell_sc_en2, done2}), 64'(0));
    chk("sat_wei_idle", 64'(wei2), 64'(0));

    for (int r = 0; r < ROWS; r++)
      chk($sformatf("lane%0d_leftover", r), 64'(exp_cyc_q[r].size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
